instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage sitting directly upstream of the instruction decoder. It owns the program counter, issues instruction reads on dual-port RAM port A, and holds each fetched word in an instruction register. It presents the word to the decoder with a valid/ready handshake and applies a branch redirect when the executing instruction resolves. It yields port A to the datapath whenever a load/store is in progress.

## Interface
- ADDR_W, 16, PC and memory address width
- DATA_W, 16, instruction width
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- mem_addr  out  ADDR_W  RAM port A address; always equals pc
- mem_en  out  1  RAM port A read request for fetch
- mem_rdata  in  DATA_W  RAM port A read data; registered, 1-cycle latency
- ls_busy  in  1  datapath owns port A for load/store; fetch must not issue
- instr  out  DATA_W  instruction register contents to decoder
- instr_valid  out  1  instr holds a fetched instruction
- instr_ready  in  1  decoder/execute accepts instr this cycle
- branch_taken  in  1  redirect PC on acceptance
- branch_target  in  ADDR_W  redirect address
- pc  out  ADDR_W  address of the current/next fetched instruction
- instr_count  out  16  accepted-instruction count (see Configuration)

## Operation
- States: IDLE, FETCH, WAIT, HOLD. Reset state IDLE.
- IDLE: mem_en=0, instr_valid=0; unconditionally -> FETCH next cycle.
- FETCH: mem_en = !ls_busy (combinational). If ls_busy=1, stay in FETCH, no request. Else request pc -> WAIT.
- WAIT: mem_en=0; capture mem_rdata into instr at the edge leaving WAIT -> HOLD. ls_busy ignored (read already issued).
- HOLD: instr_valid=1, instr stable. When instr_ready=1: pc <= branch_taken ? branch_target : pc+1; -> FETCH. When instr_ready=0: stay, pc and instr unchanged.
- branch_taken/branch_target are sampled only in HOLD with instr_ready=1; ignored otherwise.
- PC arithmetic modulo 2^ADDR_W: 0xFFFF + 1 = 0x0000.
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, mem_en=0, instr_count=0, state=IDLE.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); any in-flight read is discarded.

## Timing
- Edge 0 = first rising edge with reset=1: IDLE -> FETCH.
- FETCH with ls_busy=0 at edge N: RAM samples address at edge N; instr valid after edge N+1 (instr_valid high during cycle following N+1).
- Accept at edge M (HOLD, instr_ready=1): mem_en for the next address is high in the cycle after M.
- Sustained throughput with instr_ready tied high and ls_busy=0: one instruction every 3 cycles.
- instr_valid is registered (from state); mem_en and mem_addr are combinational from state/pc/ls_busy.
- Each ls_busy cycle in FETCH adds exactly one cycle of latency.

## Configuration
- FETCH_INSTR_COUNT_EN defined: instr_count increments by 1 on every HOLD-state acceptance (instr_ready=1), saturating at 16'hFFFF; cleared by reset.
- Not defined: counter logic absent; instr_count tied to 16'h0000. Port always present.

## Test plan
- Reset with RESET_PC=0x0010: during reset instr_valid=0, mem_en=0, pc=0x0010; after release mem_en=1, mem_addr=0x0010 in the second cycle.
- RAM[0x0010]=0xA5A5, RAM[0x0011]=0x1234, instr_ready=1: instr=0xA5A5 then 0x1234, instr_valid rising edges 3 cycles apart, pc 0x0010 -> 0x0011 -> 0x0012.
- instr_ready=0 for 5 cycles in HOLD: instr_valid stays 1, instr and pc constant, mem_en=0; accept on 6th cycle -> next fetch of pc+1.
- HOLD at pc=0x0020 with instr_ready=1, branch_taken=1, branch_target=0x0040: next mem_addr=0x0040; branch_taken=1 outside HOLD has no effect.
- ls_busy=1 for 4 cycles while in FETCH: mem_en=0 throughout, no state change; fetch issues on the cycle ls_busy falls, valid delayed by exactly 4 cycles.
- pc=0xFFFF accepted without branch -> mem_addr=0x0000; with FETCH_INSTR_COUNT_EN, 3 accepts give instr_count=3; reset pulse mid-WAIT returns instr_valid=0, instr_count=0, pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Owns the program counter, reads
//               instructions over RAM port A (registered, 1-cycle latency),
//               holds each word in an instruction register and hands it to
//               the decoder through a valid/ready handshake. A branch
//               redirect is applied when the held instruction is accepted.
//               Port A is left alone whenever the datapath signals a
//               load/store (ls_busy).
//
//               Optional feature: define FETCH_INSTR_COUNT_EN to build the
//               saturating accepted-instruction counter; otherwise
//               instr_count is tied to zero.
//
// Ports       : clk           in   system clock, rising edge
//               reset         in   asynchronous reset, active low
//               mem_addr      out  port A address (always equals pc)
//               mem_en        out  port A read request
//               mem_rdata     in   port A read data
//               ls_busy       in   datapath owns port A this cycle
//               instr         out  instruction register
//               instr_valid   out  instr holds a fetched instruction
//               instr_ready   in   decoder accepts instr this cycle
//               branch_taken  in   redirect pc on acceptance
//               branch_target in   redirect address
//               pc            out  address of current/next instruction
//               instr_count   out  accepted-instruction count
//
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              ls_busy,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] C_PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                accept;

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    accept        = 1'b0;
    mem_en        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        // Request goes out the same cycle the datapath releases port A.
        mem_en = !ls_busy;
        if (!ls_busy) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Read is already in flight, so ls_busy no longer matters here.
        instr_d       = mem_rdata;
        instr_valid_d = 1'b1;
        state_d       = ST_HOLD;
      end

      ST_HOLD: begin
        instr_valid_d = 1'b1;
        if (instr_ready) begin
          accept        = 1'b1;
          instr_valid_d = 1'b0;
          pc_d          = branch_taken ? branch_target : (pc_q + C_PC_INC);
          state_d       = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

  // --------------------------------------------------------------------------
  // Optional accepted-instruction counter (saturating)
  // --------------------------------------------------------------------------
`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] instr_count_q, instr_count_d;

  always_comb begin
    instr_count_d = instr_count_q;
    if (accept && (instr_count_q != 16'hFFFF)) begin
      instr_count_d = instr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count_q <= 16'h0000;
    end else begin
      instr_count_q <= instr_count_d;
    end
  end

  assign instr_count = instr_count_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign instr_count   = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch. Provides a
//               registered-read RAM model on port A and walks the fetch
//               stage through reset, back-to-back fetches, decoder stall,
//               branch redirect, load/store blocking, pc wrap and an
//               asynchronous reset pulse mid-read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam logic [15:0] C_RESET_PC = 16'h0010;

  logic        clk;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic [15:0] mem_rdata;
  logic        ls_busy;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] pc;
  logic [15:0] instr_count;

  logic [15:0] ram [0:65535];

  int total;
  int bad;
  int n_acc;

  instr_fetch #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .RESET_PC (C_RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_addr      (mem_addr),
    .mem_en        (mem_en),
    .mem_rdata     (mem_rdata),
    .ls_busy       (ls_busy),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .instr_count   (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM, port A.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int accepts);
`ifdef FETCH_INSTR_COUNT_EN
    chk(tag, {16'h0, instr_count}, accepts);
`else
    chk(tag, {16'h0, instr_count}, 32'h0);
`endif
  endtask

  // Advance one clock; return at the following falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n_acc = 0;
    for (int i = 0; i < 65536; i++) ram[i] = 16'(i * 7 + 16'h3C01);
    ram[16'h0010] = 16'hA5A5;
    ram[16'h0011] = 16'h1234;
    mem_rdata     = 16'h0;

    reset         = 1'b0;
    ls_busy       = 1'b0;
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0;

    // ---------------- reset state ----------------
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_pc", pc, C_RESET_PC);
    chk("rst_instr", instr, 16'h0);
    chk_cnt("rst_count", 0);

    // Release: IDLE cycle, then FETCH.
    reset = 1'b1;
    #1;
    chk("idle_mem_en", mem_en, 1'b0);
    instr_ready = 1'b1;
    step();                                      // edge 0: IDLE -> FETCH
    chk("fetch0_mem_en", mem_en, 1'b1);
    chk("fetch0_addr", mem_addr, 16'h0010);

    // ---------------- back-to-back fetches ----------------
    step();                                      // -> WAIT
    chk("wait0_mem_en", mem_en, 1'b0);
    chk("wait0_valid", instr_valid, 1'b0);
    step();                                      // -> HOLD
    chk("hold0_valid", instr_valid, 1'b1);
    chk("hold0_instr", instr, 16'hA5A5);
    chk("hold0_pc", pc, 16'h0010);
    step();                                      // accept -> FETCH 0x11
    n_acc++;
    chk("fetch1_valid", instr_valid, 1'b0);
    chk("fetch1_mem_en", mem_en, 1'b1);
    chk("fetch1_addr", mem_addr, 16'h0011);
    step();                                      // -> WAIT
    step();                                      // -> HOLD, 3 cycles after previous valid
    chk("hold1_valid", instr_valid, 1'b1);
    chk("hold1_instr", instr, 16'h1234);
    chk("hold1_pc", pc, 16'h0011);

    // ---------------- decoder stall ----------------
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_instr", instr, 16'h1234);
      chk("stall_pc", pc, 16'h0011);
      chk("stall_mem_en", mem_en, 1'b0);
    end
    instr_ready = 1'b1;
    step();                                      // accept -> FETCH 0x12
    n_acc++;
    chk("post_stall_addr", mem_addr, 16'h0012);
    chk("post_stall_mem_en", mem_en, 1'b1);
    chk_cnt("count_2", n_acc);

    // ---------------- branch ignored outside HOLD ----------------
    instr_ready   = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 16'h0077;
    step();                                      // -> WAIT
    chk("br_ign_wait_pc", pc, 16'h0012);
    step();                                      // -> HOLD (not accepted)
    chk("br_ign_hold_pc", pc, 16'h0012);
    chk("br_ign_hold_instr", instr, ram[16'h0012]);
    branch_target = 16'h0020;
    instr_ready   = 1'b1;
    step();                                      // accept with branch -> 0x20
    n_acc++;
    chk("br1_addr", mem_addr, 16'h0020);
    branch_taken  = 1'b0;
    step();                                      // -> WAIT
    step();                                      // -> HOLD at 0x20
    chk("hold20_instr", instr, ram[16'h0020]);
    chk("hold20_pc", pc, 16'h0020);
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    step();                                      // accept with branch -> 0x40
    n_acc++;
    chk("br2_addr", mem_addr, 16'h0040);
    chk("br2_mem_en", mem_en, 1'b1);

    // Branch asserted in FETCH/WAIT with ready high must not move pc.
    branch_target = 16'h0077;
    step();                                      // -> WAIT
    chk("br_ign2_pc", pc, 16'h0040);
    branch_taken = 1'b0;
    instr_ready  = 1'b0;
    step();                                      // -> HOLD
    chk("hold40_instr", instr, ram[16'h0040]);
    chk("hold40_pc", pc, 16'h0040);

    // ---------------- ls_busy blocking ----------------
    ls_busy     = 1'b1;
    instr_ready = 1'b1;
    step();                                      // accept -> FETCH 0x41, blocked
    n_acc++;
    chk("busy_mem_en_0", mem_en, 1'b0);
    chk("busy_pc_0", pc, 16'h0041);
    instr_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step();
      chk("busy_mem_en", mem_en, 1'b0);
      chk("busy_valid", instr_valid, 1'b0);
      chk("busy_pc", pc, 16'h0041);
    end
    ls_busy = 1'b0;
    #1;
    chk("busy_release_mem_en", mem_en, 1'b1);
    chk("busy_release_addr", mem_addr, 16'h0041);
    step();                                      // -> WAIT
    ls_busy = 1'b1;                              // ignored in WAIT
    chk("busy_wait_valid", instr_valid, 1'b0);
    step();                                      // -> HOLD
    chk("busy_hold_valid", instr_valid, 1'b1);
    chk("busy_hold_instr", instr, ram[16'h0041]);
    ls_busy = 1'b0;

    // ---------------- pc wrap ----------------
    instr_ready   = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 16'hFFFF;
    step();                                      // -> FETCH 0xFFFF
    n_acc++;
    chk("wrap_pre_addr", mem_addr, 16'hFFFF);
    branch_taken = 1'b0;
    step();                                      // -> WAIT
    step();                                      // -> HOLD
    chk("wrap_hold_instr", instr, ram[16'hFFFF]);
    step();                                      // accept, pc wraps
    n_acc++;
    chk("wrap_addr", mem_addr, 16'h0000);
    chk_cnt("count_7", n_acc);

    // ---------------- asynchronous reset mid-WAIT ----------------
    step();                                      // -> WAIT
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", instr_valid, 1'b0);
    chk("arst_pc", pc, C_RESET_PC);
    chk("arst_mem_en", mem_en, 1'b0);
    chk("arst_instr", instr, 16'h0);
    chk_cnt("arst_count", 0);
    step();
    chk("arst_hold_valid", instr_valid, 1'b0);
    reset = 1'b1;
    step();                                      // edge 0 again -> FETCH
    chk("rerun_addr", mem_addr, C_RESET_PC);
    chk("rerun_mem_en", mem_en, 1'b1);
    step();                                      // -> WAIT
    step();                                      // -> HOLD
    chk("rerun_valid", instr_valid, 1'b1);
    chk("rerun_instr", instr, 16'hA5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
